// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO and valid/ready write port.
// The FSM leads the registered tx/tx_done/busy outputs by one clock.
module uart_tx_fifo #(
  parameter int unsigned CLK_DIV   = 104,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned FIFO_AW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done,
  output logic [FIFO_AW:0]     fifo_count
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned BIT_W = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic [CW-1:0]        count_next;
  logic [DATA_BITS-1:0] head;
  logic [DATA_BITS-1:0] shift;
  logic [DIV_W-1:0]     div;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 par_bit;
  logic                 frame_end;
  logic                 head_par;
  logic                 tc;
  logic                 last_stop;
  logic                 pop;
  logic                 accept;
  logic                 tx_c;

  assign accept    = din_valid && din_ready;
  assign head      = mem[rd_ptr];
  assign head_par  = (PARITY == 2) ? ^head : ~^head;
  assign tc        = (div == DIV_W'(CLK_DIV - 1));
  assign last_stop = (bit_cnt == BIT_W'(STOP_BITS - 1));
  assign pop       = (fifo_count != '0) &&
                     ((state == IDLE) || (state == STOP && tc && last_stop));

  always_comb begin
    count_next = fifo_count;
    case ({accept, pop})
      2'b10:   count_next = fifo_count + CW'(1);
      2'b01:   count_next = fifo_count - CW'(1);
      default: ;
    endcase
  end

  // Storage is not reset; pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      din_ready  <= 1'b1;
    end else begin
      if (accept) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)    rd_ptr <= rd_ptr + FIFO_AW'(1);
      fifo_count <= count_next;
      din_ready  <= (count_next != CW'(DEPTH));
    end
  end

  always_comb begin
    tx_c = 1'b1;
    case (state)
      START:   tx_c = 1'b0;
      DATA:    tx_c = shift[0];
      PAR:     tx_c = par_bit;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      frame_end <= 1'b0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_end <= 1'b0;
      tx        <= tx_c;
      tx_done   <= frame_end;
      busy      <= (state != IDLE) || (fifo_count != '0);
      if (state == IDLE) begin
        div     <= '0;
        bit_cnt <= '0;
        if (pop) begin
          shift   <= head;
          par_bit <= head_par;
          state   <= START;
        end
      end else if (!tc) begin
        div <= div + DIV_W'(1);
      end else begin
        div <= '0;
        case (state)
          START: begin
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: begin
            shift <= shift >> 1;
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
          PAR: begin
            bit_cnt <= '0;
            state   <= STOP;
          end
          STOP: begin
            if (last_stop) begin
              frame_end <= 1'b1;
              bit_cnt   <= '0;
              // Chain straight into the next start bit when words are queued.
              if (pop) begin
                shift   <= head;
                par_bit <= head_par;
                state   <= START;
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four frame configurations at CLK_DIV=4,
// scoreboard of written words checked cell-by-cell against the tx line.
module tb_uart_tx_fifo;

  localparam int DIV   = 4;
  localparam int LIMIT = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] din_a  [4];
  logic       dv_a   [4];
  logic       dr_a   [4];
  logic       tx_a   [4];
  logic       busy_a [4];
  logic       done_a [4];
  logic [2:0] cnt_a  [4];
  logic [8:0] sb [$];
  int         checks = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_AW(2)) u0 (
    .clk(clk), .rst(rst), .din(din_a[0][7:0]), .din_valid(dv_a[0]), .din_ready(dr_a[0]),
    .tx(tx_a[0]), .busy(busy_a[0]), .tx_done(done_a[0]), .fifo_count(cnt_a[0]));
  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_AW(2)) u1 (
    .clk(clk), .rst(rst), .din(din_a[1][7:0]), .din_valid(dv_a[1]), .din_ready(dr_a[1]),
    .tx(tx_a[1]), .busy(busy_a[1]), .tx_done(done_a[1]), .fifo_count(cnt_a[1]));
  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_AW(2)) u2 (
    .clk(clk), .rst(rst), .din(din_a[2][7:0]), .din_valid(dv_a[2]), .din_ready(dr_a[2]),
    .tx(tx_a[2]), .busy(busy_a[2]), .tx_done(done_a[2]), .fifo_count(cnt_a[2]));
  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_AW(2)) u3 (
    .clk(clk), .rst(rst), .din(din_a[3][4:0]), .din_valid(dv_a[3]), .din_ready(dr_a[3]),
    .tx(tx_a[3]), .busy(busy_a[3]), .tx_done(done_a[3]), .fifo_count(cnt_a[3]));

  function automatic int db(input int k);
    return (k == 3) ? 5 : 8;
  endfunction

  function automatic int pm(input int k);
    return (k == 1) ? 2 : ((k == 2) ? 1 : 0);
  endfunction

  function automatic int nstop(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic logic [8:0] mask(input int k, input logic [8:0] w);
    logic [8:0] m;
    m = 9'((1 << db(k)) - 1);
    return w & m;
  endfunction

  // Expected line cells, cell i at bit i: start, data LSB first, parity, stops.
  function automatic logic [12:0] frame_bits(input int k, input logic [8:0] w);
    logic [12:0] f;
    logic        par;
    int          p;
    f = '0;
    p = 1;
    for (int i = 0; i < db(k); i++) begin
      f[p] = w[i];
      p++;
    end
    par = ^mask(k, w);
    if (pm(k) == 2) begin f[p] = par;  p++; end
    if (pm(k) == 1) begin f[p] = ~par; p++; end
    for (int i = 0; i < nstop(k); i++) begin
      f[p] = 1'b1;
      p++;
    end
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic write(input int k, input logic [8:0] w);
    int t;
    t = 0;
    din_a[k] = w;
    dv_a[k]  = 1'b1;
    while (dr_a[k] !== 1'b1 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIMIT) begin
      chk("wr_ready_timeout", 32'(dr_a[k]), 1);
      dv_a[k] = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(mask(k, w));
    @(negedge clk);
  endtask

  // Starts examining at the current negedge; ends on the last stop-cell sample.
  task automatic recv(input int k, output int lat);
    logic [12:0]    expv;
    logic [12:0]    obsv;
    logic [8:0]     w;
    logic [DIV-1:0] samp;
    logic           bad_done;
    int             n;
    lat = 0;
    while (tx_a[k] !== 1'b0 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= LIMIT) begin
      chk("rx_start_timeout", 32'(tx_a[k]), 0);
      return;
    end
    w        = (sb.size() != 0) ? sb.pop_front() : 'x;
    expv     = frame_bits(k, w);
    n        = 1 + db(k) + ((pm(k) != 0) ? 1 : 0) + nstop(k);
    obsv     = '0;
    bad_done = 1'b0;
    for (int c = 0; c < n; c++) begin
      for (int s = 0; s < DIV; s++) begin
        if (c != 0 || s != 0) begin
          @(negedge clk);
          if (done_a[k] !== 1'b0) bad_done = 1'b1;
        end
        samp[s] = tx_a[k];
      end
      obsv[c] = (samp == '0) ? 1'b0 : ((samp == '1) ? 1'b1 : 1'bx);
    end
    chk("frame_cells", 32'(obsv), 32'(expv));
    chk("done_inside_frame", 32'(bad_done), 0);
  endtask

  task automatic frame(input int k, input int exp_lat, input bit more);
    int lat;
    recv(k, lat);
    if (exp_lat >= 0) chk("start_latency", lat, exp_lat);
    @(negedge clk);
    chk("tx_done_pulse", 32'(done_a[k]), 1);
    if (more) begin
      chk("zero_idle_gap", 32'(tx_a[k]), 0);
    end else begin
      chk("busy_after_frame", 32'(busy_a[k]), 0);
      chk("tx_idle_after", 32'(tx_a[k]), 1);
    end
  endtask

  initial begin
    logic saw_low, saw_done, saw_busy;
    for (int k = 0; k < 4; k++) begin
      din_a[k] = '0;
      dv_a[k]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_tx", 32'(tx_a[k]), 1);
      chk("rst_ready", 32'(dr_a[k]), 1);
    end
    chk("rst_busy", 32'(busy_a[0]), 0);
    chk("rst_done", 32'(done_a[0]), 0);
    chk("rst_count", 32'(cnt_a[0]), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1 single word
    write(0, 9'h0A5);
    dv_a[0] = 1'b0;
    frame(0, 2, 1'b0);

    // Even and odd parity
    write(1, 9'h007);
    dv_a[1] = 1'b0;
    frame(1, 2, 1'b0);
    write(1, 9'h0C3);
    dv_a[1] = 1'b0;
    frame(1, 2, 1'b0);
    write(2, 9'h007);
    dv_a[2] = 1'b0;
    frame(2, 2, 1'b0);

    // Five data bits, two stop bits
    write(3, 9'h1FF);
    dv_a[3] = 1'b0;
    frame(3, 2, 1'b0);
    write(3, 9'h00A);
    dv_a[3] = 1'b0;
    frame(3, 2, 1'b0);

    // Back-to-back burst
    write(0, 9'h001);
    write(0, 9'h002);
    write(0, 9'h003);
    dv_a[0] = 1'b0;
    chk("burst_count", 32'(cnt_a[0]), 2);
    frame(0, -1, 1'b1);
    chk("burst_count_after1", 32'(cnt_a[0]), 1);
    frame(0, 0, 1'b1);
    chk("burst_count_after2", 32'(cnt_a[0]), 0);
    frame(0, 0, 1'b0);

    // Full FIFO with continuous valid
    fork
      begin
        write(0, 9'h011);
        write(0, 9'h022);
        write(0, 9'h033);
        write(0, 9'h044);
        write(0, 9'h055);
        din_a[0] = 9'h066;
        chk("full_ready_low", 32'(dr_a[0]), 0);
        chk("full_count", 32'(cnt_a[0]), 4);
        write(0, 9'h066);
        dv_a[0] = 1'b0;
        chk("sixth_accept_count", 32'(cnt_a[0]), 4);
      end
      begin
        for (int i = 0; i < 6; i++) frame(0, -1, i < 5);
      end
    join

    // Reset in the middle of a data bit with two words queued
    write(0, 9'h055);
    write(0, 9'h033);
    write(0, 9'h00F);
    dv_a[0] = 1'b0;
    chk("pre_rst_count", 32'(cnt_a[0]), 2);
    repeat (9) @(negedge clk);
    chk("pre_rst_tx_low", 32'(tx_a[0]), 0);
    chk("pre_rst_busy", 32'(busy_a[0]), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_tx", 32'(tx_a[0]), 1);
    chk("async_rst_count", 32'(cnt_a[0]), 0);
    chk("async_rst_busy", 32'(busy_a[0]), 0);
    chk("async_rst_ready", 32'(dr_a[0]), 1);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    saw_low  = 1'b0;
    saw_done = 1'b0;
    saw_busy = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx_a[0] !== 1'b1)   saw_low  = 1'b1;
      if (done_a[0] !== 1'b0) saw_done = 1'b1;
      if (busy_a[0] !== 1'b0) saw_busy = 1'b1;
    end
    chk("post_rst_tx_activity", 32'(saw_low), 0);
    chk("post_rst_done_pulse", 32'(saw_done), 0);
    chk("post_rst_busy", 32'(saw_busy), 0);
    write(0, 9'h03C);
    dv_a[0] = 1'b0;
    frame(0, 2, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
